// File: rtl/ysyx_23060171_isram_if.sv
// ysyx_23060171_isram_if: fetch request/response handshake plus the preload write port.
`timescale 1ns/1ps
interface ysyx_23060171_isram_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/ysyx_23060171_isram.sv
// ysyx_23060171_isram: handshaked instruction-memory responder with programmable latency.
// Define YSYX_23060171_ISRAM_RAND_DELAY_EN to add 0..3 LFSR-driven extra wait cycles.
`timescale 1ns/1ps
module ysyx_23060171_isram #(
  parameter int unsigned DEPTH   = 4096,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 1
) (
  input logic                  clk,
  input logic                  rst,
  ysyx_23060171_isram_if.slave bus
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Full 32-bit compare, so addresses below BASE never wrap into the array.
  function automatic logic addr_ok(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return (addr[1:0] == 2'b00) && (addr >= BASE) && ((off >> 2) < 32'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return IDX_W'(off >> 2);
  endfunction

  logic [31:0]      mem_r [DEPTH];
  state_t           state_r;
  logic [4:0]       cnt_r;
  logic             req_ready_r;
  logic             rsp_valid_r;
  logic [31:0]      rsp_data_r;
  logic             rsp_err_r;
  logic             req_ok_s;
  logic [IDX_W-1:0] req_idx_s;
  logic             wr_ok_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [1:0]       extra_s;
  logic [4:0]       load_s;

  assign req_ok_s  = addr_ok(bus.req_addr);
  assign req_idx_s = addr_idx(bus.req_addr);
  assign wr_ok_s   = addr_ok(bus.wr_addr);
  assign wr_idx_s  = addr_idx(bus.wr_addr);

`ifdef YSYX_23060171_ISRAM_RAND_DELAY_EN
  logic [7:0] lfsr_r;

  // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= 8'hA5;
    end else begin
      lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    end
  end

  assign extra_s = lfsr_r[1:0];
`else
  assign extra_s = 2'b00;
`endif

  assign load_s = 5'(LATENCY - 1) + {3'b000, extra_s};

  // Preload port; the array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en && wr_ok_s) begin
      mem_r[wr_idx_s] <= bus.wr_data;
    end
  end

  // Request/response state machine; every bus output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
      cnt_r       <= 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            // Old array contents are captured even if a preload hits the same word now.
            rsp_err_r   <= !req_ok_s;
            rsp_data_r  <= req_ok_s ? mem_r[req_idx_s] : 32'h0000_0000;
            cnt_r       <= load_s;
            req_ready_r <= 1'b0;
            if (load_s == 5'd0) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - 5'd1;
          if (cnt_r <= 5'd1) begin
            cnt_r       <= 5'd0;
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          rsp_data_r  <= 32'h0000_0000;
          rsp_err_r   <= 1'b0;
          cnt_r       <= 5'd0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_err   = rsp_err_r;
endmodule

// File: tb/tb_ysyx_23060171_isram.sv
// Bench for ysyx_23060171_isram: four instances (LATENCY 1..4) share stimulus, one selected at a time,
// and every response is checked against an array model of the address map and latency rules.
`timescale 1ns/1ps
module tb_ysyx_23060171_isram;
  localparam int unsigned DEPTH    = 64;
  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam logic [31:0] END_ADDR = BASE + 32'(4 * DEPTH);
  localparam int          NDUT     = 4;

  logic        clk = 1'b0;
  logic        rst;
  int          sel;
  logic        req_valid_s, rsp_ready_s, wr_en_s;
  logic [31:0] req_addr_s, wr_addr_s, wr_data_s;
  logic        rdy_a [NDUT];
  logic        vld_a [NDUT];
  logic [31:0] dat_a [NDUT];
  logic        err_a [NDUT];
  logic [31:0] ref_mem [DEPTH];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ysyx_23060171_isram_if bus_i ();
    assign bus_i.req_valid = req_valid_s && (sel == g);
    assign bus_i.req_addr  = req_addr_s;
    assign bus_i.rsp_ready = rsp_ready_s && (sel == g);
    assign bus_i.wr_en     = wr_en_s;
    assign bus_i.wr_addr   = wr_addr_s;
    assign bus_i.wr_data   = wr_data_s;
    assign rdy_a[g] = bus_i.req_ready;
    assign vld_a[g] = bus_i.rsp_valid;
    assign dat_a[g] = bus_i.rsp_data;
    assign err_a[g] = bus_i.rsp_err;
    ysyx_23060171_isram #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(g + 1)) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_i.slave)
    );
  end

  function automatic logic ref_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && (((a - BASE) / 4) < DEPTH);
  endfunction

  function automatic logic [31:0] ref_data(input logic [31:0] a);
    return ref_ok(a) ? ref_mem[(a - BASE) / 4] : 32'h0000_0000;
  endfunction

  function automatic logic lat_ok(input int lat, input int l);
`ifdef YSYX_23060171_ISRAM_RAND_DELAY_EN
    return (lat >= l) && (lat <= l + 3);
`else
    return lat == l;
`endif
  endfunction

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    wr_en_s = 1'b1; wr_addr_s = a; wr_data_s = d;
    @(posedge clk); #1;
    wr_en_s = 1'b0;
    if (ref_ok(a)) ref_mem[(a - BASE) / 4] = d;
    @(negedge clk);
  endtask

  // Drives one fetch on the selected instance and reports what it saw; callers compare.
  task automatic fetch(input logic [31:0] a, input int stall, input logic cw, input logic [31:0] cwd,
                       output int lat, output logic [31:0] d, output logic e,
                       output logic hold_ok, output logic post_ok, output logic to);
    int n;
    to = 1'b0; hold_ok = 1'b1; post_ok = 1'b1; lat = 0; d = 32'h0; e = 1'b0; n = 0;
    while (!rdy_a[sel] && n < 50) begin @(negedge clk); n++; end
    if (!rdy_a[sel]) begin to = 1'b1; return; end
    req_valid_s = 1'b1; req_addr_s = a;
    if (cw) begin wr_en_s = 1'b1; wr_addr_s = a; wr_data_s = cwd; end
    @(posedge clk); #1;
    req_valid_s = 1'b0; wr_en_s = 1'b0;
    if (cw && ref_ok(a)) ref_mem[(a - BASE) / 4] = cwd;
    do begin
      @(negedge clk); lat++;
      if (rdy_a[sel]) hold_ok = 1'b0;
    end while (!vld_a[sel] && lat < 40);
    if (!vld_a[sel]) begin to = 1'b1; return; end
    d = dat_a[sel]; e = err_a[sel];
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      if (!vld_a[sel] || dat_a[sel] !== d || err_a[sel] !== e || rdy_a[sel]) hold_ok = 1'b0;
    end
    rsp_ready_s = 1'b1;
    @(posedge clk); #1;
    rsp_ready_s = 1'b0;
    @(negedge clk);
    if (vld_a[sel] || !rdy_a[sel]) post_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < NDUT; s++) begin
      total++;
      if (rdy_a[s] !== 1'b1 || vld_a[s] !== 1'b0 || dat_a[s] !== 32'h0 || err_a[s] !== 1'b0) begin
        bad++;
        $display("FAIL reset_state lat%0d: ready=%b valid=%b data=%h err=%b, want 1 0 00000000 0",
                 s + 1, rdy_a[s], vld_a[s], dat_a[s], err_a[s]);
      end
    end
    for (int i = 0; i < DEPTH; i++) write_word(BASE + 32'(4 * i), $urandom);
  endtask

  task automatic test_basic();
    int lat; logic [31:0] d; logic e, h, p, to; logic [31:0] exp_d;
    sel = 0;
    write_word(BASE, 32'h0000_0413);
    exp_d = ref_data(BASE);
    fetch(BASE, 0, 1'b0, 32'h0, lat, d, e, h, p, to);
    total++;
    if (to !== 1'b0 || !lat_ok(lat, 1)) begin
      bad++; $display("FAIL basic_latency: got %0d (timeout=%b), want 1", lat, to);
    end
    total++;
    if (d !== exp_d || e !== 1'b0) begin
      bad++; $display("FAIL basic_data: got %h err=%b, want %h err=0", d, e, exp_d);
    end
    total++;
    if (h !== 1'b1 || p !== 1'b1) begin
      bad++; $display("FAIL basic_handshake: ready-low-while-busy=%b ready-back-after=%b, want 1 1", h, p);
    end
  endtask

  task automatic test_stall();
    int lat; logic [31:0] d; logic e, h, p, to; logic [31:0] exp_d;
    sel = 3;
    write_word(BASE + 32'h10, 32'hDEAD_BEEF);
    exp_d = ref_data(BASE + 32'h10);
    fetch(BASE + 32'h10, 3, 1'b0, 32'h0, lat, d, e, h, p, to);
    total++;
    if (to !== 1'b0 || !lat_ok(lat, 4)) begin
      bad++; $display("FAIL stall_latency: got %0d (timeout=%b), want 4", lat, to);
    end
    total++;
    if (d !== exp_d || e !== 1'b0 || h !== 1'b1 || p !== 1'b1) begin
      bad++; $display("FAIL stall_hold: got %h err=%b stable=%b post=%b, want %h 0 1 1", d, e, h, p, exp_d);
    end
  endtask

  task automatic test_faults();
    logic [31:0] addrs [$];
    int lat; logic [31:0] d; logic e, h, p, to; logic [31:0] exp_d; logic exp_e;
    sel = 1;
    write_word(BASE + 32'h5, 32'hBAD0_BAD0);
    write_word(END_ADDR, 32'hBAD1_BAD1);
    addrs = '{32'h8000_0002, 32'h7FFF_FFFC, END_ADDR, BASE + 32'(4 * (DEPTH - 1)),
              BASE + 32'h4, BASE, 32'hFFFF_FFFC};
    for (int i = 0; i < 16; i++) addrs.push_back(BASE - 32'd64 + 32'($urandom_range(0, 4 * DEPTH + 128)));
    foreach (addrs[i]) begin
      exp_e = !ref_ok(addrs[i]);
      exp_d = ref_data(addrs[i]);
      fetch(addrs[i], $urandom_range(0, 2), 1'b0, 32'h0, lat, d, e, h, p, to);
      total++;
      if (to !== 1'b0 || d !== exp_d || e !== exp_e || !lat_ok(lat, 2) || h !== 1'b1 || p !== 1'b1) begin
        bad++;
        $display("FAIL fault_map addr=%h: got data=%h err=%b lat=%0d hs=%b%b to=%b, want data=%h err=%b lat=2",
                 addrs[i], d, e, lat, h, p, to, exp_d, exp_e);
      end
    end
  endtask

  task automatic test_collision();
    int lat; logic [31:0] d; logic e, h, p, to; logic [31:0] exp_d;
    sel = 0;
    write_word(BASE + 32'h20, 32'h1111_1111);
    exp_d = ref_data(BASE + 32'h20);
    fetch(BASE + 32'h20, 0, 1'b1, 32'h2222_2222, lat, d, e, h, p, to);
    total++;
    if (to !== 1'b0 || d !== exp_d || e !== 1'b0) begin
      bad++; $display("FAIL collision_old: got %h err=%b to=%b, want %h", d, e, to, exp_d);
    end
    exp_d = ref_data(BASE + 32'h20);
    fetch(BASE + 32'h20, 0, 1'b0, 32'h0, lat, d, e, h, p, to);
    total++;
    if (to !== 1'b0 || d !== exp_d || e !== 1'b0) begin
      bad++; $display("FAIL collision_new: got %h err=%b to=%b, want %h", d, e, to, exp_d);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] d; logic e, h, p, to; logic [31:0] exp_d; logic stale;
    sel = 2;
    stale = 1'b0;
    req_valid_s = 1'b1; req_addr_s = BASE + 32'h40;
    @(posedge clk); #1 req_valid_s = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (vld_a[sel] !== 1'b0 || rdy_a[sel] !== 1'b1) begin
      bad++; $display("FAIL reset_mid_state: valid=%b ready=%b, want 0 1", vld_a[sel], rdy_a[sel]);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (vld_a[sel] !== 1'b0) stale = 1'b1;
    end
    total++;
    if (stale !== 1'b0) begin
      bad++; $display("FAIL reset_mid_stale: stale response seen=%b, want 0", stale);
    end
    exp_d = ref_data(BASE + 32'h40);
    fetch(BASE + 32'h40, 0, 1'b0, 32'h0, lat, d, e, h, p, to);
    total++;
    if (to !== 1'b0 || d !== exp_d || e !== 1'b0 || !lat_ok(lat, 3)) begin
      bad++; $display("FAIL reset_mid_refetch: got %h err=%b lat=%0d to=%b, want %h 0 3", d, e, lat, to, exp_d);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] d; logic e, h, p, to; logic [31:0] exp_d; logic [31:0] a;
    logic seen [32];
    int distinct;
    sel = 1;
    for (int i = 0; i < 32; i++) seen[i] = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i % 10 == 0) write_word(BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), $urandom);
      a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      exp_d = ref_data(a);
      fetch(a, 0, 1'b0, 32'h0, lat, d, e, h, p, to);
      if (lat < 32) seen[lat] = 1'b1;
      total++;
      if (to !== 1'b0 || d !== exp_d || e !== 1'b0 || !lat_ok(lat, 2) || p !== 1'b1) begin
        bad++;
        $display("FAIL b2b_fetch #%0d addr=%h: got %h err=%b lat=%0d post=%b to=%b, want %h 0 lat=2",
                 i, a, d, e, lat, p, to, exp_d);
      end
    end
    distinct = 0;
    for (int i = 0; i < 32; i++) if (seen[i]) distinct++;
    total++;
`ifdef YSYX_23060171_ISRAM_RAND_DELAY_EN
    if (distinct < 2) begin
      bad++; $display("FAIL b2b_latency_spread: distinct=%0d, want >=2", distinct);
    end
`else
    if (distinct != 1) begin
      bad++; $display("FAIL b2b_latency_spread: distinct=%0d, want 1", distinct);
    end
`endif
  endtask

  initial begin
    sel = 0; rst = 1'b1;
    req_valid_s = 1'b0; rsp_ready_s = 1'b0; wr_en_s = 1'b0;
    req_addr_s = 32'h0; wr_addr_s = 32'h0; wr_data_s = 32'h0;
    test_reset();
    test_basic();
    test_stall();
    test_faults();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
